// File: rtl/clk_monitor.sv
// Clock monitor for the test environment.
// Oversamples a monitored clock (sig_a) and a phase-reference clock (sig_b)
// with the fast free-running clk. Reports the sig_a period, high time and
// the sig_b-to-sig_a rising-edge offset. Flags period errors, a stuck clock
// and lock.
//
// Both inputs go through an identical 2-FF synchronizer plus an edge
// register. The 3-cycle latency is therefore common to every edge, and it
// cancels out of every interval that is measured.
//
// FSM state is held in state_q. The checker binds to it hierarchically.
module clk_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 20,
  parameter int TOL        = 1,
  parameter int TIMEOUT    = 1024,
  parameter int LOCK_CNT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_a,
  input  logic             sig_b,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] phase,
  output logic             phase_valid,
  output logic             period_err,
  output logic [7:0]       err_count,
  output logic             locked,
  output logic             stuck
);

  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [TMR_W-1:0]  TIMEOUT_V  = TMR_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] LOCK_V     = GOOD_W'(LOCK_CNT);
  localparam logic [31:0]       PER_HI_LIM = 32'(EXP_PERIOD + TOL);
  localparam logic [31:0]       PER_LO_REF = 32'(EXP_PERIOD);
  localparam logic [31:0]       TOL_V      = 32'(TOL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    MEASURE = 2'd2,
    STUCK   = 2'd3
  } state_e;

  state_e state_q;

  // Input conditioning registers.
  logic a_meta_q, a_sync_q, a_prev_q;
  logic b_meta_q, b_sync_q, b_prev_q;

  // Measurement counters.
  logic [CNT_W-1:0]  period_cnt_q;
  logic [CNT_W-1:0]  high_cnt_q;
  logic [CNT_W-1:0]  phase_cnt_q;
  logic [TMR_W-1:0]  timer_q;
  logic [GOOD_W-1:0] good_cnt_q;

  // Registered outputs.
  logic             meas_valid_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_time_q;
  logic [CNT_W-1:0] phase_q;
  logic             phase_valid_q;
  logic             period_err_q;
  logic [7:0]       err_count_q;
  logic             locked_q;
  logic             stuck_q;

  // Next-value helpers.
  logic              rise_a, rise_b;
  logic [CNT_W-1:0]  period_inc_d, high_inc_d, phase_d;
  logic [TMR_W-1:0]  timer_d;
  logic [GOOD_W-1:0] good_inc_d;
  logic [7:0]        err_inc_d;
  logic [31:0]       period_ext;
  logic              period_bad_d;

  // Edge detection and saturating increments for the counters.
  always_comb begin
    rise_a       = a_sync_q & ~a_prev_q;
    rise_b       = b_sync_q & ~b_prev_q;
    period_inc_d = (period_cnt_q == CNT_MAX) ? CNT_MAX : period_cnt_q + CNT_ONE;
    high_inc_d   = (high_cnt_q == CNT_MAX) ? CNT_MAX : high_cnt_q + CNT_ONE;
    // The phase count includes the current cycle, so a sig_b rise k cycles
    // before the sig_a rise reports k. A coincident rise reports 0.
    phase_d      = rise_b ? '0
                 : ((phase_cnt_q == CNT_MAX) ? CNT_MAX : phase_cnt_q + CNT_ONE);
    timer_d      = timer_q + TMR_W'(1);
    good_inc_d   = (good_cnt_q == LOCK_V) ? LOCK_V : good_cnt_q + GOOD_W'(1);
    err_inc_d    = (err_count_q == 8'hff) ? 8'hff : err_count_q + 8'd1;
    period_ext   = 32'(period_cnt_q);
    period_bad_d = (period_ext > PER_HI_LIM) || (period_ext + TOL_V < PER_LO_REF);
  end

  // Synchronizers, the measurement FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_meta_q      <= 1'b0;
      a_sync_q      <= 1'b0;
      a_prev_q      <= 1'b0;
      b_meta_q      <= 1'b0;
      b_sync_q      <= 1'b0;
      b_prev_q      <= 1'b0;
      state_q       <= IDLE;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      phase_cnt_q   <= '0;
      timer_q       <= '0;
      good_cnt_q    <= '0;
      meas_valid_q  <= 1'b0;
      period_q      <= '0;
      high_time_q   <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      period_err_q  <= 1'b0;
      err_count_q   <= '0;
      locked_q      <= 1'b0;
      stuck_q       <= 1'b0;
    end else begin
      a_meta_q     <= sig_a;
      a_sync_q     <= a_meta_q;
      a_prev_q     <= a_sync_q;
      b_meta_q     <= sig_b;
      b_sync_q     <= b_meta_q;
      b_prev_q     <= b_sync_q;
      meas_valid_q <= 1'b0;

      if (!enable) begin
        // Dropping enable discards any partial measurement. Results and
        // err_count hold their values.
        state_q       <= IDLE;
        period_cnt_q  <= '0;
        high_cnt_q    <= '0;
        phase_cnt_q   <= '0;
        timer_q       <= '0;
        good_cnt_q    <= '0;
        phase_valid_q <= 1'b0;
        locked_q      <= 1'b0;
        stuck_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= SEEK;
          end

          SEEK: begin
            phase_cnt_q <= phase_d;
            if (rise_a) begin
              // The first edge only opens a period. There is nothing to report yet.
              state_q       <= MEASURE;
              period_cnt_q  <= CNT_ONE;
              high_cnt_q    <= CNT_ONE;
              timer_q       <= '0;
              phase_valid_q <= 1'b0;
            end else if (timer_d == TIMEOUT_V) begin
              state_q    <= STUCK;
              stuck_q    <= 1'b1;
              locked_q   <= 1'b0;
              good_cnt_q <= '0;
            end else begin
              timer_q <= timer_d;
            end
          end

          MEASURE: begin
            phase_cnt_q <= phase_d;
            if (rise_b) begin
              phase_valid_q <= 1'b1;
            end
            if (rise_a) begin
              // Close the period just ended and open the next one.
              meas_valid_q <= 1'b1;
              period_q     <= period_cnt_q;
              high_time_q  <= high_cnt_q;
              phase_q      <= phase_d;
              period_err_q <= period_bad_d;
              period_cnt_q <= CNT_ONE;
              high_cnt_q   <= CNT_ONE;
              timer_q      <= '0;
              if (period_bad_d) begin
                good_cnt_q  <= '0;
                locked_q    <= 1'b0;
                err_count_q <= err_inc_d;
              end else begin
                good_cnt_q <= good_inc_d;
                locked_q   <= (good_inc_d == LOCK_V);
              end
            end else if (timer_d == TIMEOUT_V) begin
              state_q    <= STUCK;
              stuck_q    <= 1'b1;
              locked_q   <= 1'b0;
              good_cnt_q <= '0;
            end else begin
              period_cnt_q <= period_inc_d;
              timer_q      <= timer_d;
              if (a_sync_q) begin
                high_cnt_q <= high_inc_d;
              end
            end
          end

          STUCK: begin
            phase_cnt_q <= phase_d;
            if (rise_a) begin
              // Recovery edge reopens a period, exactly like the first edge.
              state_q       <= MEASURE;
              stuck_q       <= 1'b0;
              period_cnt_q  <= CNT_ONE;
              high_cnt_q    <= CNT_ONE;
              timer_q       <= '0;
              phase_valid_q <= 1'b0;
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign meas_valid  = meas_valid_q;
  assign period      = period_q;
  assign high_time   = high_time_q;
  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign period_err  = period_err_q;
  assign err_count   = err_count_q;
  assign locked      = locked_q;
  assign stuck       = stuck_q;

endmodule

// File: doc/clk_monitor.md
Name: clk_monitor

Overview:
- Testbench-side checker that receives generated clocks and measures them. It is the counterpart to the clock-generation side of the test environment.
- Oversamples a monitored clock (sig_a) and a phase-reference clock (sig_b) with a fast free-running clk.
- Reports period, high time and rising-edge phase offset, and flags period errors, a stuck clock, and lock.
- Sits in the test environment next to the clock drivers; its results feed the scoreboard and console logging.

Parameters:
CNT_W, 16, width of the period, high-time and phase counters
EXP_PERIOD, 20, expected sig_a period in clk cycles
TOL, 1, allowed absolute period deviation in clk cycles
TIMEOUT, 1024, clk cycles without a sig_a rise before stuck
LOCK_CNT, 4, consecutive in-tolerance periods required for lock

Ports:
clk  input  1  sampling clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  monitor enable
sig_a  input  1  monitored clock, asynchronous to clk
sig_b  input  1  phase-reference clock, asynchronous to clk
meas_valid  output  1  one-cycle pulse: new measurement
period  output  CNT_W  last sig_a period in clk cycles
high_time  output  CNT_W  clk cycles sig_a was high in the last period
phase  output  CNT_W  clk cycles from the last sig_b rise to the sig_a rise
phase_valid  output  1  a sig_b rise has been seen since entering MEASURE
period_err  output  1  qualifies meas_valid: |period-EXP_PERIOD|>TOL
err_count  output  8  saturating count of period errors
locked  output  1  LOCK_CNT consecutive good periods
stuck  output  1  no sig_a rise for TIMEOUT cycles

Behaviour:
- Reset (rst_n=0, async): all outputs 0, all counters 0, FSM=IDLE.
- Input conditioning: sig_a and sig_b each pass through a 2-FF synchronizer plus one edge register.
  - rise_x is high for the one cycle in which sync=1 and prev=0.
  - The pipeline latency is fixed at 3 cycles and identical on both inputs, so it cancels in every measurement.
- FSM states:
  - IDLE: enable=0. Counters held at 0; locked and stuck cleared; period, high_time and phase hold their last values. Goes to SEEK when enable=1.
  - SEEK: waits for the first rise_a. On rise_a, go to MEASURE with period_cnt=1 and high_cnt=sync_a. No meas_valid is issued for this edge.
  - MEASURE: period_cnt increments every cycle; high_cnt increments when sync_a=1.
    - On rise_a: period<=period_cnt, high_time<=high_cnt, phase<=phase_cnt, meas_valid=1 (registered, same edge as the updates), period_err updated, then period_cnt<=1 and high_cnt<=1.
  - STUCK: stuck=1, locked=0. On rise_a, go to MEASURE and restart counters as in SEEK, with no meas_valid. stuck clears in the same cycle.
- Result: a sig_a period of N clk cycles reports period=N; high time H reports high_time=H.
- Phase counting:
  - phase_cnt is reset to 0 on rise_b and increments otherwise.
  - If rise_a and rise_b occur in the same cycle, phase=0.
  - phase_valid is set on the first rise_b in MEASURE.
- Timeout:
  - A timer is cleared on rise_a and counts in SEEK and MEASURE.
  - When it reaches TIMEOUT, go to STUCK. This is checked in the same cycle; rise_a wins over the timeout.
- Saturation: all CNT_W counters saturate at 2^CNT_W-1 and do not wrap. err_count saturates at 255.
- Lock:
  - good_cnt increments on each in-tolerance meas_valid.
  - locked=1 once good_cnt reaches LOCK_CNT.
  - An out-of-tolerance period sets good_cnt=0, locked=0, and increments err_count.
- enable dropped at any time: go to IDLE on the next cycle; any partial measurement is discarded. err_count holds.
- Reset mid-measurement: immediate return to reset values, no meas_valid.

Test Plan:
- sig_a period 20, high 10, 6 periods, sig_b tied 0 -> first meas_valid at the 2nd rise; period=20, high_time=10, period_err=0, phase_valid=0; locked=1 at the 4th meas_valid.
- Locked, then one sig_a period of 23 -> period=23, period_err=1, locked=0, err_count=1. Four subsequent 20-cycle periods -> locked=1 again.
- sig_b rising 5 clk before each sig_a rise -> phase=5, phase_valid=1. Coincident rises -> phase=0.
- sig_a held low after a rise -> stuck=1 exactly 1024 clk after the last rise_a, locked=0. Toggling resumes -> stuck=0 at the next rise, with no meas_valid until the rise after that.
- CNT_W=8, sig_a period 300 -> period=255 (saturated), period_err=1.
- rst_n pulsed low mid-period -> all outputs 0 immediately. enable=0 mid-period -> no meas_valid; the next measurement starts from SEEK.
